// File: rtl/uart_rx_if.sv
// uart_rx_if: bus-side register interface of the USRT receive engine
// Signals are named from the receiver's point of view:
//   i_Baud       clocks per bit (clamped inside the receiver)
//   i_Parity     00/11 none, 01 even, 10 odd
//   i_Read       one-cycle pulse, bus consumed o_Data
//   o_Data       last received byte
//   o_Rx_Full    unread byte present
//   o_Busy       frame in progress
//   o_Parity_Err parity mismatch on the byte in o_Data
//   o_Frame_Err  stop bit sampled low on the byte in o_Data
//   o_Overrun    sticky, a frame completed while o_Rx_Full was set
// Modports: slave (receiver), master (status register / bus side).
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [13:0]          i_Baud;
    logic [1:0]           i_Parity;
    logic                 i_Read;
    logic [DATA_BITS-1:0] o_Data;
    logic                 o_Rx_Full;
    logic                 o_Busy;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Overrun;
    modport slave (
        input  i_Baud, i_Parity, i_Read,
        output o_Data, o_Rx_Full, o_Busy, o_Parity_Err, o_Frame_Err, o_Overrun
    );
    modport master (
        output i_Baud, i_Parity, i_Read,
        input  o_Data, o_Rx_Full, o_Busy, o_Parity_Err, o_Frame_Err, o_Overrun
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: serial receive engine deserialising 8N1/8E1/8O1 frames into the status register
// Ports:
//   i_Pclk      system/bus clock
//   i_Reset_n   asynchronous active-low reset
//   i_Rx_Serial asynchronous serial line, idle high
//   bus         uart_rx_if.slave (divisor, parity select, read strobe, data and flags)
// Optional build macro USRT_RX_MAJORITY_EN: every sample point takes a 2-of-3
// majority around the nominal sample cycle, deciding one cycle later.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int MIN_DIV   = 4
) (
    input  logic     i_Pclk,
    input  logic     i_Reset_n,
    input  logic     i_Rx_Serial,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    state_t               r_state, w_next;
    logic                 r_sync1, r_sync2;
    logic [13:0]          r_cnt, r_div;
    logic [1:0]           r_par;
    logic [CW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_full, r_perr, r_ferr, r_ovr;
    logic                 w_rx_s, w_bit, w_tick, w_par_en, w_complete;
    logic [13:0]          w_baud, w_start_load;
    assign w_rx_s     = r_sync2;
    assign w_baud     = (bus.i_Baud < 14'(MIN_DIV)) ? 14'(MIN_DIV) : bus.i_Baud;
    assign w_tick     = (r_cnt == 14'd0);
    assign w_par_en   = r_par[0] ^ r_par[1];
    assign w_complete = (r_state == STOP) && w_tick;
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_Rx_Serial;
            r_sync2 <= r_sync1;
        end
    end
`ifdef USRT_RX_MAJORITY_EN
    // r_h1 holds rx_s at the nominal sample cycle, r_h2 the cycle before;
    // the tick lands one cycle late so rx_s itself is the sample+1 vote.
    logic r_h1, r_h2;
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= w_rx_s;
            r_h2 <= r_h1;
        end
    end
    assign w_bit        = (r_h2 & r_h1) | (r_h2 & w_rx_s) | (r_h1 & w_rx_s);
    assign w_start_load = w_baud >> 1;
`else
    assign w_bit        = w_rx_s;
    assign w_start_load = (w_baud >> 1) - 14'd1;
`endif
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) r_state <= IDLE;
        else            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (!w_rx_s) w_next = START;
            START:     if (w_tick) w_next = w_bit ? IDLE : DATA;
            DATA:      if (w_tick && r_bit == LAST_BIT) w_next = w_par_en ? PARITY : STOP;
            PARITY:    if (w_tick) w_next = STOP;
            STOP:      if (w_tick) w_next = w_bit ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (w_rx_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end
    // Settings are re-latched every IDLE cycle, so the values frozen for the
    // frame are those present on the start-detect cycle.
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_cnt     <= '0;
            r_div     <= 14'(MIN_DIV);
            r_par     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else if (r_state == IDLE) begin
            r_cnt     <= w_start_load;
            r_div     <= w_baud;
            r_par     <= bus.i_Parity;
            r_bit     <= '0;
            r_par_err <= 1'b0;
        end else begin
            r_cnt <= w_tick ? r_div - 14'd1 : r_cnt - 14'd1;
            if (w_tick && r_state == DATA) begin
                r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bit   <= r_bit + CW'(1);
            end
            // r_par[1] is set only for odd parity, inverting the even check
            if (w_tick && r_state == PARITY) r_par_err <= ^r_shift ^ w_bit ^ r_par[1];
        end
    end
    // A completion in the same cycle as i_Read wins over the clear.
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_data <= '0;
            r_full <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (bus.i_Read) begin
                r_full <= 1'b0;
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_complete) begin
                if (!r_full || bus.i_Read) begin
                    r_data <= r_shift;
                    r_full <= 1'b1;
                    r_perr <= r_par_err;
                    r_ferr <= ~w_bit;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end
    assign bus.o_Data       = r_data;
    assign bus.o_Rx_Full    = r_full;
    assign bus.o_Busy       = (r_state != IDLE);
    assign bus.o_Parity_Err = r_perr;
    assign bus.o_Frame_Err  = r_ferr;
    assign bus.o_Overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    uart_rx_if bus ();
    uart_rx dut (
        .i_Pclk(clk),
        .i_Reset_n(rst_n),
        .i_Rx_Serial(rx),
        .bus(bus)
    );
    always #5 clk = ~clk;
`ifdef USRT_RX_MAJORITY_EN
    localparam int LAT_16 = 156;
`else
    localparam int LAT_16 = 155;
`endif
    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];
    logic prev_full = 1'b0;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    // Monitor: every rising o_Rx_Full must match the oldest expected entry.
    always @(negedge clk) begin
        logic [9:0] e;
        if (bus.o_Rx_Full && !prev_full) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
            chk("rx_byte", {22'd0, bus.o_Data, bus.o_Parity_Err, bus.o_Frame_Err}, {22'd0, e});
        end
        prev_full = bus.o_Rx_Full;
    end
    task automatic drive_bit(input logic v, input int b);
        rx = v;
        repeat (b) @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] d, input int b, input logic par_en,
                              input logic par_bit, input logic stop);
        drive_bit(1'b0, b);
        for (int i = 0; i < 8; i++) drive_bit(d[i], b);
        if (par_en) drive_bit(par_bit, b);
        drive_bit(stop, b);
    endtask
    task automatic read_pulse();
        bus.i_Read = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Read = 1'b0;
    endtask
    initial begin
        int n;
        bus.i_Baud = 14'd16;
        bus.i_Parity = 2'b00;
        bus.i_Read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {24'd0, bus.o_Data}, 32'h0);
        chk("reset_flags", {27'd0, bus.o_Rx_Full, bus.o_Busy, bus.o_Parity_Err,
                            bus.o_Frame_Err, bus.o_Overrun}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({8'h55, 2'b00});
        n = 0;
        fork
            send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1);
            begin
                while (n <= 400) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (bus.o_Rx_Full) break;
                end
            end
        join
        chk("latency_0x55", n, LAT_16);
        read_pulse();
        chk("read_clears_full", {31'd0, bus.o_Rx_Full}, 32'h0);
        bus.i_Parity = 2'b01;
        exp_q.push_back({8'hA3, 2'b10});
        send_frame(8'hA3, 16, 1'b1, 1'b1, 1'b1);
        chk("even_bad_perr", {31'd0, bus.o_Parity_Err}, 32'h1);
        read_pulse();
        exp_q.push_back({8'hA3, 2'b00});
        send_frame(8'hA3, 16, 1'b1, 1'b0, 1'b1);
        read_pulse();
        bus.i_Parity = 2'b10;
        exp_q.push_back({8'hA3, 2'b00});
        send_frame(8'hA3, 16, 1'b1, 1'b1, 1'b1);
        read_pulse();
        exp_q.push_back({8'h5A, 2'b10});
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b1);
        read_pulse();
        bus.i_Parity = 2'b00;
        exp_q.push_back({8'h3C, 2'b01});
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("busy_in_break", {31'd0, bus.o_Busy}, 32'h1);
        chk("frame_err", {31'd0, bus.o_Frame_Err}, 32'h1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_break", {31'd0, bus.o_Busy}, 32'h0);
        read_pulse();
        exp_q.push_back({8'h11, 2'b00});
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("overrun_keeps_data", {24'd0, bus.o_Data}, 32'h11);
        chk("overrun_flag", {30'd0, bus.o_Rx_Full, bus.o_Overrun}, 32'h3);
        read_pulse();
        chk("read_clears_all", {28'd0, bus.o_Rx_Full, bus.o_Parity_Err,
                                bus.o_Frame_Err, bus.o_Overrun}, 32'h0);
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        chk("glitch_start_seen", {31'd0, bus.o_Busy}, 32'h1);
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_rejected", {30'd0, bus.o_Busy, bus.o_Rx_Full}, 32'h0);
        exp_q.push_back({8'h0F, 2'b00});
        fork
            send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1);
            begin
                repeat (16 * 4 + 8) @(posedge clk);
                #1;
                bus.i_Baud = 14'd32;
            end
        join
        read_pulse();
        exp_q.push_back({8'hC4, 2'b00});
        send_frame(8'hC4, 32, 1'b0, 1'b0, 1'b1);
        chk("baud32_full", {31'd0, bus.o_Rx_Full}, 32'h1);
        bus.i_Baud = 14'd16;
        fork
            send_frame(8'h99, 16, 1'b0, 1'b0, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("midframe_reset_data", {24'd0, bus.o_Data}, 32'h0);
                chk("midframe_reset_flags", {27'd0, bus.o_Rx_Full, bus.o_Busy,
                                             bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Overrun}, 32'h0);
            end
        join
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("no_partial_after_reset", {30'd0, bus.o_Busy, bus.o_Rx_Full}, 32'h0);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
